ecc_feature_collector: RTL and testbench

- Producer side of the ML scrub/refresh decision path.
- Consumes a stream of ECC error events (type, row, column) and accumulates per-window statistics.
- At each window end, publishes one registered feature snapshot on a valid/ready interface. The snapshot holds the nine 16-bit features the random-forest decision engine consumes.
- Sits between the memory-controller ECC reporter and the decision engine.

---
 rtl/ecc_feature_collector.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ecc_feature_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ecc_feature_collector.sv
// ECC feature collector: accumulates per-window ECC error statistics
// and publishes one registered nine-feature snapshot per window.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   evt_valid/ready   error event handshake
//   evt_type          0=read 1=write 2=scrub 3=reserved
//   evt_row, evt_col  failing row / column
//   feat_valid/ready  snapshot handshake
//   total_errors .. error_rate_int   16-bit feature outputs
//   table_overflow    overflow flag captured with the snapshot

// Tracking table: DEPTH entries of {valid, tag, count} keyed on an address.
// uniq_o/max_o are the post-update values for this cycle (before a clear),
// so a snapshot taken this cycle includes the current event.
module ecc_track_table #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd,
    input  logic          clr,
    input  logic [W-1:0]  key,
    output logic [15:0]   uniq_o,
    output logic [15:0]   max_o,
    output logic          full_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]     tag_q [DEPTH];
    logic [W-1:0]     tag_d [DEPTH];
    logic [15:0]      cnt_q [DEPTH];
    logic [15:0]      cnt_d [DEPTH];
    logic [15:0]      uniq_q, uniq_d, uniq_n;
    logic [15:0]      max_q, max_d, max_n;
    logic             hit, free;
    logic [IW-1:0]    hit_idx, free_idx;
    logic [15:0]      new_cnt;

    // Lookup against registered state; the descending free scan leaves
    // the lowest free index selected.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && tag_q[i] == key) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        vld_d   = vld_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        uniq_n  = uniq_q;
        max_n   = max_q;
        full_o  = 1'b0;
        new_cnt = sat_inc(cnt_q[hit_idx]);
        if (upd) begin
            if (hit) begin
                cnt_d[hit_idx] = new_cnt;
                if (new_cnt > max_q) max_n = new_cnt;
            end else begin
                // A miss on a full table is still a distinct address.
                uniq_n = sat_inc(uniq_q);
                if (free) begin
                    vld_d[free_idx] = 1'b1;
                    tag_d[free_idx] = key;
                    cnt_d[free_idx] = 16'd1;
                    if (max_q == 16'd0) max_n = 16'd1;
                end else begin
                    full_o = 1'b1;
                end
            end
        end
        uniq_d = clr ? 16'd0 : uniq_n;
        max_d  = clr ? 16'd0 : max_n;
        if (clr) vld_d = '0;
    end

    assign uniq_o = uniq_n;
    assign max_o  = max_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            uniq_q <= '0;
            max_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            uniq_q <= uniq_d;
            max_q  <= max_d;
            tag_q  <= tag_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module ecc_feature_collector #(
    parameter int ROW_W         = 16,
    parameter int COL_W         = 16,
    parameter int TRACK_DEPTH   = 8,
    parameter int WINDOW_CYCLES = 1024,
    parameter int RATE_SHIFT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_valid,
    output logic             evt_ready,
    input  logic [1:0]       evt_type,
    input  logic [ROW_W-1:0] evt_row,
    input  logic [COL_W-1:0] evt_col,
    output logic             feat_valid,
    input  logic             feat_ready,
    output logic [15:0]      total_errors,
    output logic [15:0]      read_errors,
    output logic [15:0]      write_errors,
    output logic [15:0]      scrub_errors,
    output logic [15:0]      unique_rows,
    output logic [15:0]      unique_cols,
    output logic [15:0]      max_row_hits,
    output logic [15:0]      max_col_hits,
    output logic [15:0]      error_rate_int,
    output logic             table_overflow
);
    localparam int WW = $clog2(WINDOW_CYCLES);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

    typedef enum logic {COLLECT, STALL} state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e        state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [15:0]   total_q, total_d, total_n;
    logic [15:0]   read_q, read_d, read_n;
    logic [15:0]   write_q, write_d, write_n;
    logic [15:0]   scrub_q, scrub_d, scrub_n;
    logic          ovf_q, ovf_d, ovf_n;
    logic [144:0]  feat_q, feat_d;
    logic          feat_valid_q, feat_valid_d;
    logic          accept, cnt_en, snap, terminal;
    logic [15:0]   row_uniq, row_max, col_uniq, col_max;
    logic          row_full, col_full;
    logic [31:0]   rate_w;
    logic [15:0]   rate_sat;

    assign evt_ready = (state_q == COLLECT);
    assign accept    = evt_valid && evt_ready;
    assign cnt_en    = accept && (evt_type != 2'd3);
    assign terminal  = (win_q == WIN_LAST);

    ecc_track_table #(.W(ROW_W), .DEPTH(TRACK_DEPTH)) u_rows (
        .clk    (clk),
        .rst    (rst),
        .upd    (cnt_en),
        .clr    (snap),
        .key    (evt_row),
        .uniq_o (row_uniq),
        .max_o  (row_max),
        .full_o (row_full)
    );

    ecc_track_table #(.W(COL_W), .DEPTH(TRACK_DEPTH)) u_cols (
        .clk    (clk),
        .rst    (rst),
        .upd    (cnt_en),
        .clr    (snap),
        .key    (evt_col),
        .uniq_o (col_uniq),
        .max_o  (col_max),
        .full_o (col_full)
    );

    // Window FSM
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        snap    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (terminal) begin
                    if (!feat_valid_q) snap = 1'b1;
                    else state_d = STALL;
                end else begin
                    win_d = win_q + WW'(1);
                end
            end
            STALL: begin
                if (!feat_valid_q) begin
                    snap    = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        if (snap) win_d = '0;
    end

    // Counters: *_n include this cycle's event, *_d also apply the clear.
    always_comb begin
        total_n = cnt_en ? sat_inc(total_q) : total_q;
        read_n  = (cnt_en && evt_type == 2'd0) ? sat_inc(read_q) : read_q;
        write_n = (cnt_en && evt_type == 2'd1) ? sat_inc(write_q) : write_q;
        scrub_n = (cnt_en && evt_type == 2'd2) ? sat_inc(scrub_q) : scrub_q;
        ovf_n   = ovf_q | row_full | col_full;
        total_d = snap ? 16'd0 : total_n;
        read_d  = snap ? 16'd0 : read_n;
        write_d = snap ? 16'd0 : write_n;
        scrub_d = snap ? 16'd0 : scrub_n;
        ovf_d   = snap ? 1'b0 : ovf_n;
        rate_w   = 32'(total_n) << RATE_SHIFT;
        rate_sat = (rate_w > 32'h0000_FFFF) ? 16'hFFFF : rate_w[15:0];
    end

    always_comb begin
        feat_d = feat_q;
        if (snap) begin
            feat_d = {total_n, read_n, write_n, scrub_n, row_uniq,
                      col_uniq, row_max, col_max, rate_sat, ovf_n};
        end
        feat_valid_d = feat_valid_q;
        if (snap) feat_valid_d = 1'b1;
        else if (feat_valid_q && feat_ready) feat_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            win_q        <= '0;
            total_q      <= '0;
            read_q       <= '0;
            write_q      <= '0;
            scrub_q      <= '0;
            ovf_q        <= 1'b0;
            feat_q       <= '0;
            feat_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            total_q      <= total_d;
            read_q       <= read_d;
            write_q      <= write_d;
            scrub_q      <= scrub_d;
            ovf_q        <= ovf_d;
            feat_q       <= feat_d;
            feat_valid_q <= feat_valid_d;
        end
    end

    assign feat_valid = feat_valid_q;
    assign {total_errors, read_errors, write_errors, scrub_errors,
            unique_rows, unique_cols, max_row_hits, max_col_hits,
            error_rate_int, table_overflow} = feat_q;
endmodule

// File: tb/tb_ecc_feature_collector.sv
// Directed bench for ecc_feature_collector: two instances, one with a
// 16-cycle window and one with a long window for saturation.
module tb_ecc_feature_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        evt_valid = 1'b0, feat_ready = 1'b0;
    logic [1:0]  evt_type = '0;
    logic [15:0] evt_row = '0, evt_col = '0;
    logic        evt_ready, feat_valid, table_overflow;
    logic [15:0] total_errors, read_errors, write_errors, scrub_errors;
    logic [15:0] unique_rows, unique_cols, max_row_hits, max_col_hits;
    logic [15:0] error_rate_int;

    logic        evt_valid2 = 1'b0;
    logic        evt_ready2, feat_valid2, table_overflow2;
    logic [15:0] total2, read2, write2, scrub2, urows2, ucols2;
    logic [15:0] mrow2, mcol2, rate2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ecc_feature_collector #(
        .ROW_W(16), .COL_W(16), .TRACK_DEPTH(8),
        .WINDOW_CYCLES(16), .RATE_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .evt_row(evt_row), .evt_col(evt_col),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .total_errors(total_errors), .read_errors(read_errors),
        .write_errors(write_errors), .scrub_errors(scrub_errors),
        .unique_rows(unique_rows), .unique_cols(unique_cols),
        .max_row_hits(max_row_hits), .max_col_hits(max_col_hits),
        .error_rate_int(error_rate_int), .table_overflow(table_overflow)
    );

    ecc_feature_collector #(
        .ROW_W(16), .COL_W(16), .TRACK_DEPTH(8),
        .WINDOW_CYCLES(65700), .RATE_SHIFT(2)
    ) dut_sat (
        .clk(clk), .rst(rst),
        .evt_valid(evt_valid2), .evt_ready(evt_ready2),
        .evt_type(2'd0), .evt_row(16'd1), .evt_col(16'd1),
        .feat_valid(feat_valid2), .feat_ready(1'b0),
        .total_errors(total2), .read_errors(read2),
        .write_errors(write2), .scrub_errors(scrub2),
        .unique_rows(urows2), .unique_cols(ucols2),
        .max_row_hits(mrow2), .max_col_hits(mcol2),
        .error_rate_int(rate2), .table_overflow(table_overflow2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one event for the next rising edge.
    task automatic send(input logic [1:0] t, input logic [15:0] r,
                        input logic [15:0] c);
        chk("send_ready", evt_ready, 1);
        evt_valid = 1'b1;
        evt_type  = t;
        evt_row   = r;
        evt_col   = c;
        cyc(1);
        evt_valid = 1'b0;
    endtask

    task automatic chk_feat(input string tag, input logic [15:0] tot,
                            input logic [15:0] rd, input logic [15:0] wr,
                            input logic [15:0] sc, input logic [15:0] ur,
                            input logic [15:0] uc, input logic [15:0] mr,
                            input logic [15:0] mc, input logic [15:0] rate,
                            input logic ovf);
        chk({tag, "_valid"}, feat_valid, 1);
        chk({tag, "_total"}, total_errors, tot);
        chk({tag, "_read"}, read_errors, rd);
        chk({tag, "_write"}, write_errors, wr);
        chk({tag, "_scrub"}, scrub_errors, sc);
        chk({tag, "_urows"}, unique_rows, ur);
        chk({tag, "_ucols"}, unique_cols, uc);
        chk({tag, "_maxrow"}, max_row_hits, mr);
        chk({tag, "_maxcol"}, max_col_hits, mc);
        chk({tag, "_rate"}, error_rate_int, rate);
        chk({tag, "_ovf"}, table_overflow, ovf);
    endtask

    initial begin
        int waited;
        // Reset state
        cyc(2);
        chk("rst_valid", feat_valid, 0);
        chk("rst_total", total_errors, 0);
        chk("rst_rate", error_rate_int, 0);
        chk("rst_ovf", table_overflow, 0);
        rst = 1'b0;

        // Window 1: 3 reads r5/c2, 2 writes r9/c2; terminal edge 16
        repeat (3) send(2'd0, 16'd5, 16'd2);
        repeat (2) send(2'd1, 16'd9, 16'd2);
        cyc(10);
        chk("w1_early", feat_valid, 0);
        cyc(1);
        chk_feat("w1", 5, 3, 2, 0, 2, 1, 3, 5, 5, 0);
        feat_ready = 1'b1;
        cyc(1);
        chk("w1_taken", feat_valid, 0);
        feat_ready = 1'b0;

        // Window 2: 10 scrubs to distinct rows overflow the row table
        for (int i = 0; i < 10; i++) send(2'd2, 16'(100 + i), 16'd0);
        cyc(4);
        chk("w2_early", feat_valid, 0);
        cyc(1);
        chk_feat("w2", 10, 0, 0, 10, 10, 1, 1, 10, 10, 1);

        // Window 3 with feat_ready low: stall at terminal edge 48
        cyc(1);
        send(2'd1, 16'd7, 16'd3);
        cyc(13);
        chk("w3_ready_pre", evt_ready, 1);
        chk("w3_hold_pre", total_errors, 10);
        send(2'd0, 16'd7, 16'd3);
        chk("w3_stall_ready", evt_ready, 0);
        chk("w3_stall_valid", feat_valid, 1);
        chk("w3_hold_total", total_errors, 10);
        cyc(2);
        chk("w3_hold_urows", unique_rows, 10);
        chk("w3_still_stall", evt_ready, 0);
        feat_ready = 1'b1;
        cyc(1);
        chk("w3_fall", feat_valid, 0);
        feat_ready = 1'b0;
        cyc(1);
        chk_feat("w3", 2, 1, 1, 0, 1, 1, 2, 2, 2, 0);
        chk("w3_resume", evt_ready, 1);

        // Window 4: event on the terminal cycle lands in this snapshot
        feat_ready = 1'b1;
        cyc(1);
        feat_ready = 1'b0;
        chk("w4_taken", feat_valid, 0);
        cyc(1);
        send(2'd0, 16'd2, 16'd1);
        cyc(12);
        chk("w4_early", feat_valid, 0);
        send(2'd2, 16'd1, 16'd1);
        chk_feat("w4", 2, 1, 0, 1, 2, 1, 1, 2, 2, 0);

        // Window 5 starts at 0: one write on its first cycle
        feat_ready = 1'b1;
        send(2'd1, 16'd3, 16'd3);
        feat_ready = 1'b0;
        chk("w5_taken", feat_valid, 0);
        cyc(14);
        chk("w5_early", feat_valid, 0);
        cyc(1);
        chk_feat("w5", 1, 0, 1, 0, 1, 1, 1, 1, 1, 0);

        // Window 6 stalls at edge 100; reset mid-STALL
        cyc(6);
        send(2'd0, 16'd8, 16'd8);
        cyc(9);
        chk("w6_stall", evt_ready, 0);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst2_valid", feat_valid, 0);
        chk("rst2_total", total_errors, 0);
        chk("rst2_urows", unique_rows, 0);
        chk("rst2_maxcol", max_col_hits, 0);
        chk("rst2_ovf", table_overflow, 0);
        chk("rst2_ready", evt_ready, 1);
        send(2'd0, 16'd4, 16'd4);
        cyc(14);
        chk("w7_early", feat_valid, 0);
        cyc(1);
        chk_feat("w7", 1, 1, 0, 0, 1, 1, 1, 1, 1, 0);

        // Saturation on the long-window instance
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("sat_ready", evt_ready2, 1);
        evt_valid2 = 1'b1;
        cyc(65600);
        evt_valid2 = 1'b0;
        waited = 0;
        while (!feat_valid2 && waited < 200) begin
            cyc(1);
            waited++;
        end
        chk("sat_wait", feat_valid2, 1);
        chk("sat_total", total2, 16'hFFFF);
        chk("sat_read", read2, 16'hFFFF);
        chk("sat_write", write2, 0);
        chk("sat_maxrow", mrow2, 16'hFFFF);
        chk("sat_urows", urows2, 1);
        chk("sat_rate", rate2, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
